// File: rtl/clk_div_monitor_if.sv
// clk_div_monitor_if
//   Bundles the monitored divider wave and the measurement results.
//   Parameter CNT_W sets the width of the length fields and must match
//   the CNT_W of the attached clk_div_monitor.
//   Signals:
//     div_in      divided square wave under test
//     meas_valid  one-cycle pulse, new lengths available
//     high_len    high time of the last complete period
//     low_len     low time of the last complete period
//     period_len  high_len + low_len, saturating
//     locked      period matched the expected value long enough
//     stall       no edge seen for the timeout window
//   Modports: slave = monitor side, master = stimulus/consumer side.
interface clk_div_monitor_if #(parameter int CNT_W = 16);
  logic             div_in;
  logic             meas_valid;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
  logic [CNT_W-1:0] period_len;
  logic             locked;
  logic             stall;

  modport slave  (input  div_in,
                  output meas_valid, high_len, low_len, period_len, locked, stall);
  modport master (output div_in,
                  input  meas_valid, high_len, low_len, period_len, locked, stall);
endinterface

// File: rtl/clk_div_monitor.sv
// clk_div_monitor
//   Measures high time, low time and period of a divided square wave in
//   the sys_clk domain, flags lock after LOCK_CNT consecutive periods of
//   EXP_PERIOD cycles and flags stall after TIMEOUT cycles without an edge.
//   Ports:
//     sys_clk  system clock, rising edge
//     sys_rst  synchronous active-high reset
//     bus      clk_div_monitor_if.slave (div_in in, measurement results out)
//   Optional feature: define DIV_MON_SYNC_EN to put a 2-flop synchronizer
//   on div_in (adds 2 cycles to every edge-related event, lengths unchanged).
module clk_div_monitor #(
  parameter int CNT_W      = 16,
  parameter int EXP_PERIOD = 6,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  clk_div_monitor_if.slave bus
);
  localparam int IDLE_W  = $clog2(TIMEOUT + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;

  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]   EXP_P    = CNT_W'(EXP_PERIOD);
  localparam logic [IDLE_W-1:0]  IDLE_LIM = IDLE_W'(TIMEOUT);
  localparam logic [MATCH_W-1:0] LOCK_M   = MATCH_W'(LOCK_CNT);

  logic               w_div_s, w_rise, w_fall, w_edge, w_timeout;
  logic               r_div_d;
  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_hcnt, r_lcnt, r_h_hold;
  logic [IDLE_W-1:0]  r_idle;
  logic [MATCH_W-1:0] r_match, w_match_nxt;
  logic [CNT_W:0]     w_psum;
  logic [CNT_W-1:0]   w_period_sat;
  logic               r_meas_valid, r_locked, r_stall;
  logic [CNT_W-1:0]   r_high_len, r_low_len, r_period_len;

`ifdef DIV_MON_SYNC_EN
  // Synchronizer flops run freely through reset so div_s already reflects
  // the real level when reset releases.
  logic [1:0] r_sync;
  always_ff @(posedge sys_clk) r_sync <= {r_sync[0], bus.div_in};
  assign w_div_s = r_sync[1];
`else
  assign w_div_s = bus.div_in;
`endif

  assign w_rise = w_div_s & ~r_div_d;
  assign w_fall = ~w_div_s & r_div_d;
  assign w_edge = w_rise | w_fall;
  // An edge arriving in the timeout cycle wins over the stall.
  assign w_timeout = (r_idle == IDLE_LIM) && !w_edge;

  assign w_psum       = {1'b0, r_h_hold} + {1'b0, r_lcnt};
  assign w_period_sat = w_psum[CNT_W] ? CNT_MAX : w_psum[CNT_W-1:0];

  // Match count is updated from the registered measurement so locked can
  // follow the meas_valid pulse by exactly one cycle.
  always_comb begin
    w_match_nxt = r_match;
    if (r_meas_valid) begin
      if (r_period_len == EXP_P)
        w_match_nxt = (r_match == LOCK_M) ? r_match : r_match + 1'b1;
      else
        w_match_nxt = '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    // div_d tracks div_s even in reset: a wave already high at release is
    // not mistaken for a rise.
    r_div_d <= w_div_s;
    if (sys_rst) begin
      r_state      <= S_WAIT;
      r_hcnt       <= '0;
      r_lcnt       <= '0;
      r_h_hold     <= '0;
      r_idle       <= '0;
      r_match      <= '0;
      r_meas_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_stall      <= 1'b0;
      r_high_len   <= '0;
      r_low_len    <= '0;
      r_period_len <= '0;
    end else begin
      r_meas_valid <= 1'b0;
      if (w_edge)                r_idle <= '0;
      else if (r_idle != IDLE_LIM) r_idle <= r_idle + 1'b1;

      r_match  <= w_timeout ? '0   : w_match_nxt;
      r_locked <= w_timeout ? 1'b0 : (w_match_nxt == LOCK_M);

      if (w_timeout)   r_stall <= 1'b1;
      else if (w_rise) r_stall <= 1'b0;

      if (w_timeout) begin
        r_state <= S_WAIT;
      end else begin
        case (r_state)
          S_WAIT: if (w_rise) begin
            r_hcnt  <= CNT_W'(1);
            r_state <= S_HIGH;
          end
          S_HIGH: if (w_fall) begin
            r_h_hold <= r_hcnt;
            r_lcnt   <= CNT_W'(1);
            r_state  <= S_LOW;
          end else if (w_div_s && r_hcnt != CNT_MAX) begin
            r_hcnt <= r_hcnt + 1'b1;
          end
          S_LOW: if (w_rise) begin
            r_high_len   <= r_h_hold;
            r_low_len    <= r_lcnt;
            r_period_len <= w_period_sat;
            r_meas_valid <= 1'b1;
            r_hcnt       <= CNT_W'(1);
            r_state      <= S_HIGH;
          end else if (!w_div_s && r_lcnt != CNT_MAX) begin
            r_lcnt <= r_lcnt + 1'b1;
          end
          default: r_state <= S_WAIT;
        endcase
      end
    end
  end

  assign bus.meas_valid = r_meas_valid;
  assign bus.high_len   = r_high_len;
  assign bus.low_len    = r_low_len;
  assign bus.period_len = r_period_len;
  assign bus.locked     = r_locked;
  assign bus.stall      = r_stall;
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor
//   Directed bench for clk_div_monitor. dut0 uses CNT_W=16, dut1 uses
//   CNT_W=4 for saturation; both watch the same div_in. Expected values
//   are hand-computed; LAT adds the synchronizer delay when
//   DIV_MON_SYNC_EN is defined.
module tb_clk_div_monitor;
`ifdef DIV_MON_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    int lo;   // low cycles driven before the rise
    int hi;   // high cycles driven after the rise (>= 2)
    bit mv;   // rise should complete a measurement
    int eh, el, ep;
    bit lk;   // locked one cycle after the measurement slot
  } vec_t;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic div     = 1'b0;
  int   n_vec = 0, n_err = 0, mv_cnt = 0;

  always #5 sys_clk = ~sys_clk;

  clk_div_monitor_if #(.CNT_W(16)) b0 ();
  clk_div_monitor_if #(.CNT_W(4))  b1 ();
  assign b0.div_in = div;
  assign b1.div_in = div;

  clk_div_monitor #(.CNT_W(16)) dut0 (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(b0));
  clk_div_monitor #(.CNT_W(4))  dut1 (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(b1));

  always @(negedge sys_clk) if (b0.meas_valid === 1'b1) mv_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // drive a level for one cycle, return just after the rising edge
  task automatic cyc(input logic lvl);
    div = lvl;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic periods(input int n, input int h, input int l);
    repeat (n) begin
      repeat (h) cyc(1'b1);
      repeat (l) cyc(1'b0);
    end
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    repeat (2) cyc(1'b0);
    sys_rst = 1'b0;
  endtask

  // started right after the first high cycle of a record
  task automatic chk_rise(input vec_t v, input int idx);
    repeat (LAT) begin @(posedge sys_clk); #1; end
    chk($sformatf("tbl%0d meas_valid", idx), 32'(b0.meas_valid), 32'(v.mv));
    if (v.mv) begin
      chk($sformatf("tbl%0d high_len", idx),   32'(b0.high_len),   v.eh);
      chk($sformatf("tbl%0d low_len", idx),    32'(b0.low_len),    v.el);
      chk($sformatf("tbl%0d period_len", idx), 32'(b0.period_len), v.ep);
    end
    @(posedge sys_clk); #1;
    chk($sformatf("tbl%0d pulse_end", idx), 32'(b0.meas_valid), 32'd0);
    chk($sformatf("tbl%0d locked", idx),    32'(b0.locked),     32'(v.lk));
  endtask

  task automatic run_table();
    vec_t tbl[20];
    tbl[0] = '{2, 3, 1'b0, 0, 0, 0, 1'b0};  // first rise only arms
    for (int i = 1; i <= 3; i++) tbl[i] = '{3, 3, 1'b1, 3, 3, 6, 1'b0};
    for (int i = 4; i <= 9; i++) tbl[i] = '{3, 3, 1'b1, 3, 3, 6, 1'b1};
    tbl[10] = '{3, 4, 1'b1, 3, 3, 6, 1'b1};  // starts a 4/3 period
    tbl[11] = '{3, 3, 1'b1, 4, 3, 7, 1'b0};  // lock lost
    for (int i = 12; i <= 14; i++) tbl[i] = '{3, 3, 1'b1, 3, 3, 6, 1'b0};
    tbl[15] = '{3, 3, 1'b1, 3, 3, 6, 1'b1};  // 4th match relocks
    tbl[16] = '{3, 2, 1'b1, 3, 3, 6, 1'b1};
    for (int i = 17; i <= 19; i++) tbl[i] = '{5, 2, 1'b1, 2, 5, 7, 1'b0};
    for (int i = 0; i < 20; i++) begin
      automatic vec_t v = tbl[i];
      automatic int   k = i;
      repeat (v.lo) cyc(1'b0);
      cyc(1'b1);
      fork chk_rise(v, k); join_none
      repeat (v.hi - 1) cyc(1'b1);
    end
    repeat (LAT + 3) cyc(1'b0);
  endtask

  initial begin
    int mv0;
    // reset values
    sys_rst = 1'b1;
    repeat (3) cyc(1'b0);
    chk("rst meas_valid", 32'(b0.meas_valid), 0);
    chk("rst high_len",   32'(b0.high_len),   0);
    chk("rst low_len",    32'(b0.low_len),    0);
    chk("rst period_len", 32'(b0.period_len), 0);
    chk("rst locked",     32'(b0.locked),     0);
    chk("rst stall",      32'(b0.stall),      0);
    chk("rst period1",    32'(b1.period_len), 0);
    sys_rst = 1'b0;

    run_table();

    // stall after a long low time, then recovery
    do_reset();
    periods(6, 3, 3);
    repeat (1000) cyc(1'b0);
    chk("pre_stall stall",  32'(b0.stall),  0);
    chk("pre_stall locked", 32'(b0.locked), 1);
    repeat (30) cyc(1'b0);
    chk("stall stall",  32'(b0.stall),  1);
    chk("stall locked", 32'(b0.locked), 0);
    mv0 = mv_cnt;
    repeat (1 + LAT) cyc(1'b1);
    chk("stall_clr stall", 32'(b0.stall),      0);
    chk("stall_clr mv",    32'(b0.meas_valid), 0);
    repeat (2 - LAT) cyc(1'b1);
    repeat (3) cyc(1'b0);
    chk("stall_arm count", mv_cnt, mv0);
    repeat (1 + LAT) cyc(1'b1);
    chk("stall_meas mv",     32'(b0.meas_valid), 1);
    chk("stall_meas period", 32'(b0.period_len), 6);

    // reset in the middle of a high phase
    periods(6, 3, 3);
    repeat (2) cyc(1'b1);
    chk("pre_rst locked", 32'(b0.locked), 1);
    sys_rst = 1'b1;
    cyc(1'b1);
    chk("mid_rst high_len",   32'(b0.high_len),   0);
    chk("mid_rst low_len",    32'(b0.low_len),    0);
    chk("mid_rst period_len", 32'(b0.period_len), 0);
    chk("mid_rst locked",     32'(b0.locked),     0);
    chk("mid_rst stall",      32'(b0.stall),      0);
    cyc(1'b1);
    sys_rst = 1'b0;
    repeat (2) cyc(1'b1);
    mv0 = mv_cnt;
    periods(1, 0, 3);
    periods(1, 3, 3);
    chk("mid_rst arm count", mv_cnt, mv0);
    repeat (1 + LAT) cyc(1'b1);
    chk("mid_rst meas mv",   32'(b0.meas_valid), 1);
    chk("mid_rst meas high", 32'(b0.high_len),   3);
    chk("mid_rst meas low",  32'(b0.low_len),    3);

    // saturation on the narrow instance
    do_reset();
    repeat (2) cyc(1'b0);
    periods(1, 3, 3);
    periods(1, 20, 3);
    repeat (1 + LAT) cyc(1'b1);
    chk("sat mv",      32'(b1.meas_valid), 1);
    chk("sat high",    32'(b1.high_len),   15);
    chk("sat low",     32'(b1.low_len),    3);
    chk("sat period",  32'(b1.period_len), 15);
    chk("wide high",   32'(b0.high_len),   20);
    chk("wide period", 32'(b0.period_len), 23);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
